// File: rtl/signal_write_arbiter_if.sv
// Write-port bundle between the two requesters, the arbiter and the signal generator.
interface signal_write_arbiter_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 5;

  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              ack_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              ack_b;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              grant_id;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  ack_a, ack_b, wr_strobe, wr_address, wr_data, busy, grant_id
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output ack_a, ack_b, wr_strobe, wr_address, wr_data, busy, grant_id
  );
endinterface

// File: rtl/signal_write_arbiter.sv
// Round-robin arbiter that stretches each granted register write into a
// setup / strobe / release sequence for the slow-clocked signal generator.
module signal_write_arbiter #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 128,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  signal_write_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_SH > GAP_CYCLES) ? MAX_SH : GAP_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              pick_b_c;

  // On a tie, B wins only if A was the last requester served.
  assign pick_b_c = bus.req_b && (!bus.req_a || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack_a_d      = 1'b0;
    ack_b_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          addr_d       = pick_b_c ? bus.addr_b : bus.addr_a;
          data_d       = pick_b_c ? bus.data_b : bus.data_a;
          grant_d      = pick_b_c;
          last_grant_d = pick_b_c;
          ack_a_d      = !pick_b_c;
          ack_b_d      = pick_b_c;
          cnt_d        = CNT_W'(SETUP_CYCLES - 1);
          state_d      = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Registered from next state so strobe and busy track the state exactly.
    strobe_d = (state_d == STROBE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.wr_strobe  = strobe_q;
  assign bus.wr_address = addr_q;
  assign bus.wr_data    = data_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
endmodule

// File: doc/signal_write_arbiter.md
# signal_write_arbiter

Arbitrates and sequences register writes into the signal generator's configuration port (write strobe, 3-bit address, 5-bit data). Two requesters share the port: A is the pin-driven host path and B is an on-chip pattern player. The block uses round-robin arbitration. Each granted write is stretched into a long setup / strobe / release sequence, so the signal generator samples it reliably on its slow scaled clock. It runs on the fast system clock, between the requesters and the signal generator's `write_strobe` / `address` / `data` inputs.

## Interface

Parameters:
- `SETUP_CYCLES`, default 4: cycles that address/data are stable before the strobe rises (≥1).
- `HOLD_CYCLES`, default 128: cycles the strobe stays high (≥1). Must be ≥ 2× the scaled-clock period.
- `GAP_CYCLES`, default 4: cycles that address/data are held after the strobe falls (≥1).

Ports (clock and reset first):
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in 1: requester A valid. Held with payload until `ack_a`.
- `addr_a` in 3: requester A register address.
- `data_a` in 5: requester A register data.
- `ack_a` out 1: one-cycle pulse; A's write has been accepted.
- `req_b`, `addr_b`, `data_b`, `ack_b`: same as A, for requester B.
- `wr_strobe` out 1: to signal generator `write_strobe`.
- `wr_address` out 3: to signal generator `address`.
- `wr_data` out 5: to signal generator `data`.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out 1: source of the current or last write (0 = A, 1 = B).

## Operation

- States: IDLE, SETUP, STROBE, RELEASE. There is one down-counter, sized to `$clog2` of the largest parameter (+1).
- IDLE:
  - If either request is high at a clock edge, latch the winner's addr/data into `wr_address`/`wr_data` and set `grant_id`.
  - Pulse the winner's ack for exactly the next cycle, load the counter with `SETUP_CYCLES-1`, and go to SETUP.
- Arbitration:
  - A single request wins.
  - If both are high, the winner is the requester not granted last. A `last_grant` register resets to B, so A wins the first tie.
  - The loser's request stays pending and is not acked.
- SETUP: `wr_strobe` = 0. When the counter reaches 0, load `HOLD_CYCLES-1` and go to STROBE.
- STROBE: `wr_strobe` = 1. When the counter reaches 0, load `GAP_CYCLES-1` and go to RELEASE.
- RELEASE: `wr_strobe` = 0. When the counter reaches 0, go to IDLE.
- `wr_address`/`wr_data` change only on a grant. Between transactions they hold the last value.
- Requests are ignored outside IDLE.
  - A requester may deassert the cycle it sees ack, or keep valid high to queue the next write (new payload).
  - A valid that is still high in IDLE is treated as a new request. Requesters must drop valid the cycle after ack unless they have another write.
- Reset (at any time, including mid-strobe):
  - Next edge: state IDLE, `wr_strobe` = 0, `wr_address` = 0, `wr_data` = 0, `ack_a` = `ack_b` = 0, `busy` = 0, `grant_id` = 0, `last_grant` = B, counter = 0.
  - The in-flight write is abandoned and never acked again. Requesters re-present after reset.

## Timing

- Request seen in IDLE at edge N:
  - Cycle N+1: ack high, `busy` high, address/data valid, strobe low.
  - Strobe is high for cycles N+1+`SETUP_CYCLES` through N+`SETUP_CYCLES`+`HOLD_CYCLES`.
  - RELEASE occupies the next `GAP_CYCLES` cycles.
  - IDLE (`busy` = 0) resumes at N+1+S+H+G.
- A request present on that IDLE cycle is granted at the same edge. Sustained throughput is one write per 1+S+H+G cycles.
- Ack is a registered single-cycle pulse; `ack_a` and `ack_b` are never high together.
- `wr_strobe` is a glitch-free register output. Address/data are stable from one full SETUP window before strobe rise to one full GAP window after strobe fall.

## Test plan

Bench uses `SETUP_CYCLES`=2, `HOLD_CYCLES`=4, `GAP_CYCLES`=2.

1. **Single write.** `req_a` with addr=5, data=0x13.
   - `ack_a` pulses on the next cycle.
   - `wr_address`=5 and `wr_data`=0x13 from that cycle.
   - Strobe high for exactly 4 cycles starting 3 cycles after the request edge.
   - `busy` low 9 cycles after the request edge.
2. **Tie after reset.** `req_a` and `req_b` both asserted in the same cycle.
   - A is acked first.
   - B is acked when the arbiter returns to IDLE.
   - `grant_id` is 0 then 1; two full strobe sequences, no overlap.
3. **Round-robin fairness.** Both requests held high and each re-requesting after ack for 6 transactions.
   - Grants alternate A, B, A, B, A, B.
4. **Back-to-back single requester.** B keeps valid high with a new payload after each ack.
   - Grants every 9 cycles.
   - Address/data never change during SETUP/STROBE/RELEASE.
5. **Reset mid-strobe.** Assert `rst` on the 2nd STROBE cycle.
   - Next cycle: strobe, address, data, busy and ack are all 0.
   - A fresh `req_b` after reset is acked normally.
6. **Request during busy.** Raise `req_a` only during STROBE, then drop it before IDLE.
   - No ack.
   - No further strobe.
